// File: rtl/mem_instr_pipe_if.sv
// Request/response/load bundle for the instruction memory pipe.
// The producer/consumer side uses master; the memory uses slave.
interface mem_instr_pipe_if #(
  parameter int WORD_LEN = 16,
  parameter int ADDR_LEN = 16
);

  logic                req_valid;
  logic [ADDR_LEN-1:0] req_addr;
  logic                req_ready;
  logic                resp_valid;
  logic [WORD_LEN-1:0] resp_data;
  logic                resp_err;
  logic                resp_ready;
  logic                ld_en;
  logic [ADDR_LEN-1:0] ld_addr;
  logic [WORD_LEN-1:0] ld_data;

  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/mem_instr_pipe.sv
// Instruction memory with a fixed-latency read pipeline, an in-order response
// buffer and credit-based request flow control; program-load write port on the side.
module mem_instr_pipe #(
  parameter int WORD_LEN   = 16,
  parameter int ADDR_LEN   = 16,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  mem_instr_pipe_if.slave bus
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUF_DEPTH = FIFO_DEPTH - 1;
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_LEN:0]   DEPTH_EXT = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]    PTR_ZERO  = PTR_W'(0);
  localparam logic [WORD_LEN-1:0] WORD_ZERO = WORD_LEN'(0);

  // Buffer depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = PTR_ZERO;
    end else begin
      r = p + PTR_ONE;
    end
    return r;
  endfunction

  logic [WORD_LEN-1:0] mem_r [0:DEPTH-1];

  logic                ready_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                accept_s;
  logic                pop_s;
  logic                ld_ok_s;
  logic                rd_err_s;
  logic [WORD_LEN-1:0] rd_data_s;

  logic                push_v_s;
  logic                push_e_s;
  logic [WORD_LEN-1:0] push_d_s;

  logic [WORD_LEN-1:0] buf_d_r [0:BUF_DEPTH-1];
  logic [BUF_DEPTH-1:0] buf_e_r;
  logic [PTR_W-1:0]    buf_wr_r;
  logic [PTR_W-1:0]    buf_rd_r;
  logic [CNT_W-1:0]    buf_cnt_r;
  logic [CNT_W-1:0]    buf_cnt_nxt_s;
  logic                out_free_s;
  logic                buf_empty_s;
  logic                buf_pop_s;
  logic                buf_push_s;
  logic                push_to_out_s;

  logic                out_v_r;
  logic                out_e_r;
  logic [WORD_LEN-1:0] out_d_r;

  assign accept_s = bus.req_valid & ready_r;
  assign pop_s    = out_v_r & bus.resp_ready;
  assign ld_ok_s  = rst & bus.ld_en & ({1'b0, bus.ld_addr} < DEPTH_EXT);

  // Memory read at accept time; the array updates with NBAs, so a same-edge load is not seen
  always_comb begin
    rd_err_s  = 1'b0;
    rd_data_s = WORD_ZERO;
    if ({1'b0, bus.req_addr} >= DEPTH_EXT) begin
      rd_err_s  = 1'b1;
      rd_data_s = WORD_ZERO;
    end else begin
      rd_err_s  = 1'b0;
      rd_data_s = mem_r[bus.req_addr[IDX_W-1:0]];
    end
  end

  // Program-load write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      mem_r[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign push_v_s = accept_s;
    assign push_d_s = rd_data_s;
    assign push_e_s = rd_err_s;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;

    logic [STAGES-1:0]   v_r;
    logic [STAGES-1:0]   e_r;
    logic [WORD_LEN-1:0] d_r [0:STAGES-1];

    // Read pipeline; the final stage's output is written into the response buffer
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_r <= {STAGES{1'b0}};
        e_r <= {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
          d_r[i] <= WORD_ZERO;
        end
      end else begin
        v_r[0] <= accept_s;
        e_r[0] <= rd_err_s;
        d_r[0] <= rd_data_s;
        for (int i = 1; i < STAGES; i++) begin
          v_r[i] <= v_r[i-1];
          e_r[i] <= e_r[i-1];
          d_r[i] <= d_r[i-1];
        end
      end
    end

    assign push_v_s = v_r[STAGES-1];
    assign push_d_s = d_r[STAGES-1];
    assign push_e_s = e_r[STAGES-1];
  end

  // Response store = output register plus BUF_DEPTH entries behind it; credits bound occupancy
  always_comb begin
    out_free_s    = ~out_v_r | pop_s;
    buf_empty_s   = (buf_cnt_r == CNT_ZERO);
    buf_pop_s     = out_free_s & ~buf_empty_s;
    push_to_out_s = push_v_s & out_free_s & buf_empty_s;
    buf_push_s    = push_v_s & ~push_to_out_s;

    cnt_nxt_s = cnt_r;
    if (accept_s && !pop_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (!accept_s && pop_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    buf_cnt_nxt_s = buf_cnt_r;
    if (buf_push_s && !buf_pop_s) begin
      buf_cnt_nxt_s = buf_cnt_r + CNT_ONE;
    end else if (!buf_push_s && buf_pop_s) begin
      buf_cnt_nxt_s = buf_cnt_r - CNT_ONE;
    end else begin
      buf_cnt_nxt_s = buf_cnt_r;
    end
  end

  // Credits, registered ready, response buffer and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r   <= 1'b0;
      cnt_r     <= CNT_ZERO;
      buf_cnt_r <= CNT_ZERO;
      buf_wr_r  <= PTR_ZERO;
      buf_rd_r  <= PTR_ZERO;
      buf_e_r   <= {BUF_DEPTH{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_d_r[i] <= WORD_ZERO;
      end
      out_v_r <= 1'b0;
      out_e_r <= 1'b0;
      out_d_r <= WORD_ZERO;
    end else begin
      cnt_r     <= cnt_nxt_s;
      ready_r   <= (cnt_nxt_s < CNT_MAX);
      buf_cnt_r <= buf_cnt_nxt_s;
      if (buf_push_s) begin
        buf_d_r[buf_wr_r] <= push_d_s;
        buf_e_r[buf_wr_r] <= push_e_s;
        buf_wr_r          <= ptr_inc(buf_wr_r);
      end
      if (buf_pop_s) begin
        buf_rd_r <= ptr_inc(buf_rd_r);
        out_v_r  <= 1'b1;
        out_d_r  <= buf_d_r[buf_rd_r];
        out_e_r  <= buf_e_r[buf_rd_r];
      end else if (push_to_out_s) begin
        out_v_r <= 1'b1;
        out_d_r <= push_d_s;
        out_e_r <= push_e_s;
      end else if (pop_s) begin
        out_v_r <= 1'b0;
        out_d_r <= WORD_ZERO;
        out_e_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.resp_valid = out_v_r;
  assign bus.resp_data  = out_d_r;
  assign bus.resp_err   = out_e_r;

endmodule

// File: tb/tb_mem_instr_pipe.sv
// Directed self-checking bench for mem_instr_pipe at default parameters
// (LATENCY=2, FIFO_DEPTH=4, DEPTH=256).
module tb_mem_instr_pipe;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_instr_pipe_if #(.WORD_LEN(16), .ADDR_LEN(16)) bus ();

  mem_instr_pipe #(
    .WORD_LEN(16), .ADDR_LEN(16), .DEPTH(256), .LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0000", bus.resp_data); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_before_edge: got %b want 0", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_after_edge: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] exp [0:3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    do_load(16'h0000, 16'h1111);
    do_load(16'h0001, 16'h2222);
    do_load(16'h0002, 16'h3333);
    do_load(16'h0003, 16'h4444);
    do_load(16'h0005, 16'h1234);
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 6) begin
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle c=%0d: got %b want 0", c, bus.resp_valid); end
      end
      if (c >= 2 && c <= 5) begin
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b want 1", c, bus.resp_valid); end
        n_checks++; if (bus.resp_data !== exp[c-2]) begin n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, bus.resp_data, exp[c-2]); end
      end
      if (c < 4) begin
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b want 1", c, bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_addr = 16'(c);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [0:3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 14) begin
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b want 1", c, bus.resp_valid); end
        n_checks++; if (bus.resp_data !== exp[(c-2)%4]) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h want %h", c, bus.resp_data, exp[(c-2)%4]); end
      end
      if (c == 14) begin
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", bus.resp_valid); end
      end
      if (c < 12) begin
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b want 1", c, bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_addr = 16'(c % 4);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [0:3];
    int acc;
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    acc = 0;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 16'(acc);
      if (bus.req_ready === 1'b1) acc++;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %b want 1", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== exp[0]) begin n_fail++; $display("FAIL bp_held_data: got %h want %h", bus.resp_data, exp[0]); end
    bus.resp_ready = 1'b1;
    for (int d = 1; d < 4; d++) begin
      @(negedge clk);
      n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid d=%0d: got %b want 1", d, bus.resp_valid); end
      n_checks++; if (bus.resp_data !== exp[d]) begin n_fail++; $display("FAIL bp_drain_data d=%0d: got %h want %h", d, bus.resp_data, exp[d]); end
      if (d == 1) begin
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.req_ready); end
      end
    end
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_range_err();
    do_load(16'd257, 16'hDEAD);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 16'd256;
    @(negedge clk);
    bus.req_addr = 16'd255;
    @(negedge clk);
    bus.req_addr = 16'd1;
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL oor_valid: got %b want 1", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL oor_data: got %h want 0000", bus.resp_data); end
    n_checks++; if (bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", bus.resp_err); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL last_valid: got %b want 1", bus.resp_valid); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL last_err: got %b want 0", bus.resp_err); end
    @(negedge clk);
    n_checks++; if (bus.resp_data !== 16'h2222) begin n_fail++; $display("FAIL oor_load_ignored: got %h want 2222", bus.resp_data); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL addr1_err: got %b want 0", bus.resp_err); end
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL idle_data: got %h want 0000", bus.resp_data); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b want 0", bus.resp_err); end
  endtask

  task automatic test_rbw();
    @(negedge clk);
    bus.ld_en = 1'b1; bus.ld_addr = 16'd5; bus.ld_data = 16'hBEEF;
    bus.req_valid = 1'b1; bus.req_addr = 16'd5;
    @(negedge clk);
    bus.ld_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.resp_data !== 16'h1234) begin n_fail++; $display("FAIL rbw_old: got %h want 1234", bus.resp_data); end
    @(negedge clk);
    n_checks++; if (bus.resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL rbw_new: got %h want beef", bus.resp_data); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 16'(c);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL prerst_valid: got %b want 1", bus.resp_valid); end
    #2;
    rst = 1'b0;
    bus.ld_en = 1'b1; bus.ld_addr = 16'd0; bus.ld_data = 16'hDEAD;
    #1;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL async_data: got %h want 0000", bus.resp_data); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %b want 0", bus.req_ready); end
    @(negedge clk);
    @(negedge clk);
    bus.ld_en = 1'b0;
    rst = 1'b1;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL stale_resp k=%0d: got %b want 0", k, bus.resp_valid); end
      if (k == 0) begin
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.req_ready); end
      end
    end
    bus.req_valid = 1'b1; bus.req_addr = 16'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL fresh_valid: got %b want 1", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 16'h1111) begin n_fail++; $display("FAIL fresh_data: got %h want 1111", bus.resp_data); end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.resp_ready = 1'b1;
    bus.ld_en      = 1'b0;
    bus.ld_addr    = 16'h0000;
    bus.ld_data    = 16'h0000;
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_range_err();
    test_rbw();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_instr_pipe.md
MEM_INSTR_PIPE -- requirements
Module: mem_instr_pipe

Interface
REQ-001 Parameter WORD_LEN, default 16, instruction word width in bits.
REQ-002 Parameter ADDR_LEN, default 16, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of stored words; SHALL satisfy DEPTH <= 2**ADDR_LEN.
REQ-004 Parameter LATENCY, default 2, read pipeline stages; legal range 1..4.
REQ-005 Parameter FIFO_DEPTH, default 4, response buffer entries; SHALL satisfy FIFO_DEPTH >= LATENCY+1.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset: asserted while 0, released on 1.
REQ-008 req_valid  input  1  read request present.
REQ-009 req_addr  input  ADDR_LEN  word address of request.
REQ-010 req_ready  output  1  block accepts a request this cycle.
REQ-011 resp_valid  output  1  resp_data/resp_err hold a response.
REQ-012 resp_data  output  WORD_LEN  instruction word read.
REQ-013 resp_err  output  1  response address was >= DEPTH.
REQ-014 resp_ready  input  1  consumer takes the response this cycle.
REQ-015 ld_en  input  1  program-load write strobe.
REQ-016 ld_addr  input  ADDR_LEN  load address.
REQ-017 ld_data  input  WORD_LEN  load data.

Function
REQ-018 Request accepted on an edge where req_valid && req_ready; response pushed in order into the FIFO after LATENCY edges.
REQ-019 Accept on edge k, FIFO empty, no backpressure -> resp_valid=1 from just after edge k+LATENCY-1, i.e. LATENCY=1 gives the response the cycle after accept.
REQ-020 Responses return strictly in request order; none dropped or duplicated.
REQ-021 Response popped on an edge where resp_valid && resp_ready; resp_data/resp_err stay stable while resp_valid && !resp_ready.
REQ-022 Credit counter cnt (0..FIFO_DEPTH) = in-flight requests + FIFO entries; +1 on accept, -1 on pop, unchanged on simultaneous accept and pop.
REQ-023 req_ready = (cnt < FIFO_DEPTH); no combinational path from resp_ready or req_valid to req_ready.
REQ-024 With resp_ready held 1, one request accepted every cycle indefinitely (steady cnt = LATENCY).
REQ-025 req_addr >= DEPTH -> resp_data = 0, resp_err = 1; otherwise resp_err = 0.
REQ-026 ld_en=1 and ld_addr < DEPTH -> mem[ld_addr] <= ld_data at the edge; ld_addr >= DEPTH ignored silently.
REQ-027 Load and request to the same address on the same edge -> response returns old contents (read-before-write); request on the following edge returns new data.
REQ-028 Loads never stall and do not affect req_ready or cnt.
REQ-029 Memory contents are uninitialised at power-up apart from optional $readmemh preload; simulation models SHALL return X only for never-written in-range words.
REQ-030 While resp_valid=0, resp_data and resp_err SHALL be 0.

Reset
REQ-031 rst=0 asynchronously clears the pipeline, FIFO pointers and cnt; resp_valid=0, resp_data=0, resp_err=0, req_ready=0 while rst=0.
REQ-032 First edge after rst returns to 1: req_ready=1; requests in flight at reset are discarded and never returned.
REQ-033 Reset does not alter memory contents; ld_en is ignored while rst=0.

Verification
REQ-034 Load 0x0000..0x0003 with 0x1111,0x2222,0x3333,0x4444, then back-to-back requests 0..3 with resp_ready=1 -> resp_data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, first one LATENCY cycles after first accept.
REQ-035 resp_ready=0, continuous req_valid -> exactly FIFO_DEPTH accepts, req_ready=0 afterward; raising resp_ready drains all FIFO_DEPTH responses in order, req_ready=1 the cycle after the first pop.
REQ-036 Request addr=DEPTH (256) -> resp_data=0x0000, resp_err=1; next request addr=255 -> resp_err=0.
REQ-037 Same-edge ld_en addr 5 data 0xBEEF (old 0x1234) and request addr 5 -> response 0x1234; next request addr 5 -> 0xBEEF.
REQ-038 Drive rst=0 mid-cycle with 3 requests in flight -> resp_valid falls immediately without waiting for clk; after release no stale response appears, and a fresh request addr 0 returns 0x1111.
